// File: rtl/bootloader_if.sv
// rtl/bootloader_if.sv - bootload handshake and bus bundle between rx source, bootloader and control
interface bootloader_if #(
    parameter int DATA_W = 8
);
    logic              boot_start;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              bootload_address;
    logic              bootload_ram;
    logic [DATA_W-1:0] boot_bus;
    logic              cpu_hold;
    logic              boot_done;
    logic              boot_error;

    // Image source side: offers start requests and bytes, observes the bootloader.
    modport master (
        output boot_start,
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  bootload_address,
        input  bootload_ram,
        input  boot_bus,
        input  cpu_hold,
        input  boot_done,
        input  boot_error
    );

    // Bootloader side: consumes bytes, drives the bus strobes and CPU hold.
    modport slave (
        input  boot_start,
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output bootload_address,
        output bootload_ram,
        output boot_bus,
        output cpu_hold,
        output boot_done,
        output boot_error
    );
endinterface

// File: rtl/bootloader.sv
// rtl/bootloader.sv - byte-stream image loader writing RAM via the shared bus; optional checksum via BOOTLOADER_CHECKSUM_EN
module bootloader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    bootloader_if.slave bl
);

    localparam int unsigned MAX_LEN = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_WAIT_BYTE,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic [DATA_W-1:0] byte_q;
    logic              rx_ready_q;
    logic              addr_stb_q;
    logic              ram_stb_q;
    logic [DATA_W-1:0] boot_bus_q;
    logic              cpu_hold_q;
    logic              boot_done_q;
    logic              boot_error_q;
`ifdef BOOTLOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
`endif

    logic rx_fire;
    logic len_ok;
    logic last_byte;

    // Handshake and length qualification; rx_ready_q is only ever high in byte-accepting states.
    always_comb begin
        rx_fire   = bl.rx_valid & rx_ready_q;
        len_ok    = (bl.rx_data != '0) && (32'(bl.rx_data) <= MAX_LEN);
        last_byte = (remain_q == (ADDR_W + 1)'(1));
    end

    // Load sequencer; every output is a register updated together with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            byte_q       <= '0;
            rx_ready_q   <= 1'b0;
            addr_stb_q   <= 1'b0;
            ram_stb_q    <= 1'b0;
            boot_bus_q   <= '0;
            cpu_hold_q   <= 1'b0;
            boot_done_q  <= 1'b0;
            boot_error_q <= 1'b0;
`ifdef BOOTLOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            // Strobes and the done pulse last exactly one cycle unless re-armed below.
            addr_stb_q  <= 1'b0;
            ram_stb_q   <= 1'b0;
            boot_bus_q  <= '0;
            boot_done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bl.boot_start) begin
                        state_q      <= S_LEN;
                        cpu_hold_q   <= 1'b1;
                        boot_error_q <= 1'b0;
                        addr_q       <= '0;
                        rx_ready_q   <= 1'b1;
                    end
                end

                S_LEN: begin
`ifdef BOOTLOADER_CHECKSUM_EN
                    sum_q <= '0;
`endif
                    if (rx_fire) begin
                        if (len_ok) begin
                            remain_q <= (ADDR_W + 1)'(bl.rx_data);
                            state_q  <= S_WAIT_BYTE;
                        end else begin
                            rx_ready_q   <= 1'b0;
                            boot_error_q <= 1'b1;
                            state_q      <= S_ERR;
                        end
                    end
                end

                S_WAIT_BYTE: begin
                    if (rx_fire) begin
                        byte_q     <= bl.rx_data;
                        rx_ready_q <= 1'b0;
                        addr_stb_q <= 1'b1;
                        boot_bus_q <= DATA_W'(addr_q);
                        state_q    <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    ram_stb_q  <= 1'b1;
                    boot_bus_q <= byte_q;
                    state_q    <= S_DATA;
                end

                S_DATA: begin
                    // The address may roll over after the final byte of a full-size image; it is
                    // reloaded at the next start, so no wrap is ever visible on the bus.
                    addr_q   <= addr_q + ADDR_W'(1);
                    remain_q <= remain_q - (ADDR_W + 1)'(1);
`ifdef BOOTLOADER_CHECKSUM_EN
                    sum_q    <= sum_q + byte_q;
`endif
                    if (last_byte) begin
`ifdef BOOTLOADER_CHECKSUM_EN
                        rx_ready_q <= 1'b1;
                        state_q    <= S_CSUM;
`else
                        boot_done_q <= 1'b1;
                        cpu_hold_q  <= 1'b0;
                        state_q     <= S_DONE;
`endif
                    end else begin
                        rx_ready_q <= 1'b1;
                        state_q    <= S_WAIT_BYTE;
                    end
                end

`ifdef BOOTLOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (rx_fire) begin
                        rx_ready_q <= 1'b0;
                        if (bl.rx_data == sum_q) begin
                            boot_done_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                            state_q     <= S_DONE;
                        end else begin
                            boot_error_q <= 1'b1;
                            state_q      <= S_ERR;
                        end
                    end
                end
`endif

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                // The CPU stays held after a bad image until a later good load releases it.
                S_ERR: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    rx_ready_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bl.rx_ready         = rx_ready_q;
    assign bl.bootload_address = addr_stb_q;
    assign bl.bootload_ram     = ram_stb_q;
    assign bl.boot_bus         = boot_bus_q;
    assign bl.cpu_hold         = cpu_hold_q;
    assign bl.boot_done        = boot_done_q;
    assign bl.boot_error       = boot_error_q;

endmodule

// File: tb/tb_bootloader.sv
// tb/tb_bootloader.sv - randomized self-checking bench for bootloader against a behavioural load model
module tb_bootloader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int MAXL   = 16;

    logic clk;
    logic rst;

    bootloader_if #(.DATA_W(DATA_W)) bl ();

    bootloader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bl  (bl)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int data_stb_cnt = 0;

    logic [8:0]        exp_q[$];
    logic [7:0]        img [0:MAXL];
    logic [7:0]        ram [0:MAXL-1];
    bit                written [0:MAXL-1];
    logic [ADDR_W-1:0] cur_addr;
    logic [8:0]        mon_e;
    bit                prev_addr;
    bit                prev_hold;
    int                acc_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Per-cycle observer: bus rules, strobe sequence vs model queue, RAM model.
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs_zero",
                {bl.rx_ready, bl.bootload_address, bl.bootload_ram, bl.cpu_hold,
                 bl.boot_done, bl.boot_error, bl.boot_bus}, 0);
            prev_addr = 0;
            prev_hold = 0;
        end else begin
            chk("strobe_exclusive", 32'(bl.bootload_address & bl.bootload_ram), 0);
            if (!bl.bootload_address && !bl.bootload_ram)
                chk("bus_zero_without_strobe", bl.boot_bus, 0);
            chk("ram_strobe_iff_prev_addr", bl.bootload_ram, prev_addr);
            if (bl.bootload_address) begin
                chk("addr_strobe_one_cycle", prev_addr, 0);
                cur_addr = bl.boot_bus[ADDR_W-1:0];
                if (exp_q.size() == 0) chk("unexpected_addr_strobe", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("addr_strobe_value", {1'b0, bl.boot_bus}, mon_e);
                end
            end
            if (bl.bootload_ram) begin
                ram[cur_addr] = bl.boot_bus;
                written[cur_addr] = 1'b1;
                data_stb_cnt++;
                if (exp_q.size() == 0) chk("unexpected_data_strobe", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("data_strobe_value", {1'b1, bl.boot_bus}, mon_e);
                end
            end
            chk("hold_falls_with_done", 32'(prev_hold & ~bl.cpu_hold), bl.boot_done);
            if (bl.boot_done) done_cnt++;
            prev_addr = bl.bootload_address;
            prev_hold = bl.cpu_hold;
        end
    end

    task automatic start_boot();
        @(posedge clk); #1;
        bl.boot_start = 1'b1;
        @(posedge clk); #1;
        bl.boot_start = 1'b0;
        chk("start_rx_ready", bl.rx_ready, 1);
        chk("start_cpu_hold", bl.cpu_hold, 1);
        chk("start_error_cleared", bl.boot_error, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit noisy, input bit gaps);
        int n;
        bit got;
        if (gaps && $urandom_range(0, 1) == 1) begin
            bl.rx_valid = 1'b0;
            bl.rx_data  = 8'($urandom);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        bl.rx_valid = 1'b1;
        bl.rx_data  = b;
        got = 0;
        n = 0;
        while (!got && n < 60) begin
            bl.boot_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (bl.rx_ready) got = 1;
            else begin
                @(posedge clk); #1;
            end
            n++;
        end
        chk("rx_accept_timeout", got, 1);
        @(posedge clk); #1;
        acc_cyc.push_back(cyc);
        bl.boot_start = 1'b0;
    endtask

    task automatic load(input int len, input bit corrupt, input bit noisy);
        bit len_ok;
        bit exp_done;
        bit seen;
        int d0;
        int s;
        int k;
        len_ok   = (len >= 1 && len <= MAXL);
        exp_done = len_ok;
        s = 0;
`ifdef BOOTLOADER_CHECKSUM_EN
        exp_done = len_ok && !corrupt;
`endif
        for (int i = 0; i < MAXL; i++) written[i] = 0;
        if (len_ok)
            for (int i = 0; i < len; i++) begin
                exp_q.push_back({1'b0, 8'(i)});
                exp_q.push_back({1'b1, img[i]});
            end
        acc_cyc.delete();
        start_boot();
        d0 = done_cnt;
        send_byte(8'(len), 0, 0);
        if (len_ok) begin
            for (int i = 0; i < len; i++) send_byte(img[i], noisy, noisy);
`ifdef BOOTLOADER_CHECKSUM_EN
            for (int i = 0; i < len; i++) s = s + int'(img[i]);
            s = s % 256;
            if (corrupt) s = (s + 1) % 256;
            send_byte(8'(s), 0, noisy);
`endif
        end
        bl.rx_valid = 1'b0;
        seen = 0;
        k = 0;
        while (!seen && k < 80) begin
            @(negedge clk);
            k++;
            if (bl.boot_done || bl.boot_error) seen = 1;
        end
        chk("outcome_timeout", seen, 1);
        chk("outcome_done", bl.boot_done, exp_done);
        chk("outcome_error", bl.boot_error, !exp_done);
        chk("outcome_hold", bl.cpu_hold, !exp_done);
        repeat (3) @(negedge clk);
        chk("done_pulse_count", done_cnt - d0, exp_done);
        chk("error_sticky", bl.boot_error, !exp_done);
        chk("hold_after_outcome", bl.cpu_hold, !exp_done);
        chk("strobe_queue_drained", exp_q.size(), 0);
        if (len_ok)
            for (int i = 0; i < len; i++) begin
                chk("ram_written", written[i], 1);
                chk("ram_value", ram[i], img[i]);
            end
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int s;
        rst = 1'b1;
        bl.boot_start = 1'b0;
        bl.rx_valid   = 1'b0;
        bl.rx_data    = '0;

        // Reset held with random inputs.
        repeat (20) begin
            @(posedge clk); #1;
            bl.boot_start = 1'($urandom_range(0, 1));
            bl.rx_valid   = 1'($urandom_range(0, 1));
            bl.rx_data    = 8'($urandom);
        end
        bl.boot_start = 1'b0;
        bl.rx_valid   = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle",
            {bl.rx_ready, bl.bootload_address, bl.bootload_ram, bl.cpu_hold,
             bl.boot_done, bl.boot_error, bl.boot_bus}, 0);

        // Three-byte image, back to back.
        img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0;
        load(3, 0, 0);
        chk("t2_ram0", ram[0], 8'h1E);
        chk("t2_ram1", ram[1], 8'h2F);
        chk("t2_ram2", ram[2], 8'hE0);
`ifndef BOOTLOADER_CHECKSUM_EN
        chk("t2_accept_count", acc_cyc.size(), 4);
        chk("t2_first_byte_gap", acc_cyc[1] - acc_cyc[0], 1);
        chk("t2_byte_gap_a", acc_cyc[2] - acc_cyc[1], 3);
        chk("t2_byte_gap_b", acc_cyc[3] - acc_cyc[2], 3);
`endif

        // Full-size image, then out-of-range lengths.
        for (int i = 0; i < MAXL; i++) img[i] = 8'($urandom);
        load(16, 0, 0);
        load(0, 0, 0);
        load(17, 0, 0);

        // Random images with gaps, held rx_valid and stray boot_start.
        for (int t = 0; t < 6; t++) begin
            k = $urandom_range(1, MAXL);
            for (int i = 0; i < MAXL; i++) img[i] = 8'($urandom);
            load(k, 0, 1);
        end

        // Reset after two of five bytes, then a full reload.
        for (int i = 0; i < 5; i++) img[i] = 8'($urandom);
        for (int i = 0; i < MAXL; i++) written[i] = 0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b0, 8'(i)});
            exp_q.push_back({1'b1, img[i]});
        end
        base = data_stb_cnt;
        start_boot();
        send_byte(8'd5, 0, 0);
        send_byte(img[0], 0, 0);
        send_byte(img[1], 0, 0);
        bl.rx_valid = 1'b0;
        k = 0;
        while (data_stb_cnt < base + 2 && k < 40) begin
            @(posedge clk);
            k++;
        end
        chk("t5_two_bytes_seen", 32'(data_stb_cnt - base), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_immediate",
            {bl.rx_ready, bl.bootload_address, bl.bootload_ram, bl.cpu_hold,
             bl.boot_done, bl.boot_error, bl.boot_bus}, 0);
        exp_q.delete();
        chk("t5_partial_written", {written[0], written[1], written[2]}, 3'b110);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        load(5, 0, 0);

`ifdef BOOTLOADER_CHECKSUM_EN
        img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'hFF;
        s = (int'(img[0]) + int'(img[1]) + int'(img[2])) % 256;
        chk("t6_checksum_model", s, 8'h02);
        load(3, 0, 0);
        load(3, 1, 0);
        chk("t6_bad_csum_error", bl.boot_error, 1);
        chk("t6_bad_csum_hold", bl.cpu_hold, 1);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
